// File: rtl/fpu_wb_if.sv
// Bundle of the FPU-to-writeback and writeback-to-regfile signals.
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The in_* channel is special in that
// ready is raised only once the stage has captured the result or consumed a
// no-op; upstream keeps in_valid and its payload stable until then. On the
// wb_* channel the stage keeps wb_valid/wb_addr/wb_data stable until wb_ready.
interface fpu_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [5:0]  in_reg_addr;
  logic [31:0] in_dd_val;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pend_valid;
  logic [5:0]  pend_addr;

  // Upstream FPU plus register file side.
  modport master (
    output in_valid, in_ctrl, in_reg_addr, in_dd_val, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, pend_valid, pend_addr
  );

  // The writeback stage itself.
  modport slave (
    input  in_valid, in_ctrl, in_reg_addr, in_dd_val, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, pend_valid, pend_addr
  );
endinterface

// File: rtl/fpu_wb_stage.sv
// Writeback stage behind the combinational FPU. Waits a per-opcode number of
// cycles so the FPU paths settle as multicycle paths, captures the result,
// and holds it until the register file takes it. The pending destination is
// exported so issue logic can stall on hazards.
module fpu_wb_stage #(
  parameter int ARITH_LAT = 2,
  parameter int DIV_LAT   = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fpu_wb_if.slave          bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt,
  output logic [3:0]       dbg_ctrl
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Counter preload is LAT-2; the arm is only used when LAT > 1.
  localparam int ARITH_M2_I = (ARITH_LAT >= 2) ? ARITH_LAT - 2 : 0;
  localparam int DIV_M2_I   = (DIV_LAT >= 2) ? DIV_LAT - 2 : 0;
  localparam logic [CNT_W-1:0] ARITH_M2 = CNT_W'(ARITH_M2_I);
  localparam logic [CNT_W-1:0] DIV_M2   = CNT_W'(DIV_M2_I);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       a_reg;
  logic [3:0]       c_reg;
  logic [31:0]      d_reg;

  logic             is_nop;
  logic             lat_one;
  logic [CNT_W-1:0] lat_m2;
  logic             no_wb;

  // Decode the latency class of the opcode presented by the FPU.
  always_comb begin
    is_nop  = 1'b0;
    lat_one = 1'b1;
    lat_m2  = '0;
    if (bus.in_ctrl == 4'd0 || bus.in_ctrl == 4'd15) begin
      is_nop = 1'b1;
    end else if (bus.in_ctrl <= 4'd3) begin
      lat_one = (ARITH_LAT == 1);
      lat_m2  = ARITH_M2;
    end else if (bus.in_ctrl <= 4'd5) begin
      lat_one = (DIV_LAT == 1);
      lat_m2  = DIV_M2;
    end
  end

  // Ops that never produce a register write: no-ops and writes to x0.
  assign no_wb = is_nop || (bus.in_reg_addr == 6'd0);

  // Upstream ready: raised the cycle the result is captured or the op dropped.
  always_comb begin
    bus.in_ready = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE:    bus.in_ready = bus.in_valid && (no_wb || lat_one);
        WAIT:    bus.in_ready = (cnt == '0);
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  // Output views; address and data read as zero whenever they are not valid.
  always_comb begin
    bus.wb_valid   = (state == OUT);
    bus.wb_addr    = bus.wb_valid ? a_reg : 6'd0;
    bus.wb_data    = bus.wb_valid ? d_reg : 32'd0;
    bus.pend_valid = (state == WAIT) || (state == OUT);
    bus.pend_addr  = bus.pend_valid ? a_reg : 6'd0;
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;
  assign dbg_ctrl  = c_reg;

  // Control FSM and result capture; reset beats flush beats normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      c_reg <= '0;
      d_reg <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !no_wb) begin
            a_reg <= bus.in_reg_addr;
            if (lat_one) begin
              d_reg <= bus.in_dd_val;
              state <= OUT;
            end else begin
              c_reg <= bus.in_ctrl;
              cnt   <= lat_m2;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            d_reg <= bus.in_dd_val;
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Directed bench for fpu_wb_stage: a table of single-op vectors plus
// hand-written sequences for back-pressure, flush and reset corners.
module tb_fpu_wb_stage;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;
  logic [3:0] dbg_ctrl;

  fpu_wb_if bus ();

  fpu_wb_stage #(.ARITH_LAT(2), .DIV_LAT(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt),
    .dbg_ctrl  (dbg_ctrl)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [5:0]  addr;
    logic [31:0] data;
    int          exp_rdy;  // cycle (from presentation) when in_ready rises
    bit          exp_wb;   // a writeback is expected the following cycle
  } vec_t;

  vec_t vecs[12];

  // Scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_ctrl     = 4'd0;
    bus.in_reg_addr = 6'd0;
    bus.in_dd_val   = 32'd0;
  endtask

  // Driver: present one op with wb_ready high and check handshake timing.
  task automatic run_op(input vec_t v);
    int rdy_at;
    bit pend_bad;
    rdy_at   = -1;
    pend_bad = 1'b0;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = v.ctrl;
    bus.in_reg_addr = v.addr;
    bus.in_dd_val   = v.data;
    bus.wb_ready    = 1'b1;
    for (int c = 0; c < 12 && rdy_at < 0; c++) begin
      #1;
      if (bus.in_ready) rdy_at = c;
      if (c >= 1 && (!bus.pend_valid || bus.pend_addr != v.addr)) pend_bad = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    chk({v.name, " ready_cycle"}, rdy_at, v.exp_rdy);
    chk({v.name, " pend_during_wait"}, {31'd0, pend_bad}, 32'd0);
    #1;
    chk({v.name, " wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, v.exp_wb});
    chk({v.name, " pend_valid"}, {31'd0, bus.pend_valid}, {31'd0, v.exp_wb});
    chk({v.name, " in_ready_out"}, {31'd0, bus.in_ready}, 32'd0);
    if (v.exp_wb) begin
      chk({v.name, " wb_addr"}, {26'd0, bus.wb_addr}, {26'd0, v.addr});
      chk({v.name, " wb_data"}, bus.wb_data, v.data);
      chk({v.name, " pend_addr"}, {26'd0, bus.pend_addr}, {26'd0, v.addr});
    end
    @(negedge clk);
    #1;
    chk({v.name, " back_idle"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"fmul",      4'd3,  6'd5,  32'h40400000, 1, 1'b1};
    vecs[1]  = '{"fadd",      4'd1,  6'd12, 32'h3F800000, 1, 1'b1};
    vecs[2]  = '{"fsub",      4'd2,  6'd63, 32'hC0000000, 1, 1'b1};
    vecs[3]  = '{"fdiv",      4'd4,  6'd9,  32'h3EAAAAAB, 3, 1'b1};
    vecs[4]  = '{"fsqrt",     4'd5,  6'd33, 32'h3FB504F3, 3, 1'b1};
    vecs[5]  = '{"ctrl6",     4'd6,  6'd1,  32'h12345678, 0, 1'b1};
    vecs[6]  = '{"fneg",      4'd11, 6'd7,  32'hBF800000, 0, 1'b1};
    vecs[7]  = '{"ctrl14",    4'd14, 6'd40, 32'hDEADBEEF, 0, 1'b1};
    vecs[8]  = '{"nop0",      4'd0,  6'd4,  32'h11111111, 0, 1'b0};
    vecs[9]  = '{"nop15",     4'd15, 6'd4,  32'h22222222, 0, 1'b0};
    vecs[10] = '{"fsub_x0",   4'd2,  6'd0,  32'h33333333, 0, 1'b0};
    vecs[11] = '{"fdiv_x0",   4'd4,  6'd0,  32'h44444444, 0, 1'b0};

    rst = 1'b1;
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = 4'd6;
    bus.in_reg_addr = 6'd2;
    bus.in_dd_val   = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst pend_valid", {31'd0, bus.pend_valid}, 32'd0);
    chk("rst wb_addr", {26'd0, bus.wb_addr}, 32'd0);
    chk("rst wb_data", bus.wb_data, 32'd0);
    chk("rst state", {30'd0, dbg_state}, 32'd0);
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Back-pressure: fneg held in OUT while wb_ready stays low.
    @(negedge clk);
    bus.wb_ready    = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = 4'd11;
    bus.in_reg_addr = 6'd7;
    bus.in_dd_val   = 32'hBF800000;
    #1;
    chk("bp accept_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("bp hold%0d wb_valid", c), {31'd0, bus.wb_valid}, 32'd1);
      chk($sformatf("bp hold%0d wb_data", c), bus.wb_data, 32'hBF800000);
      chk($sformatf("bp hold%0d wb_addr", c), {26'd0, bus.wb_addr}, 32'd7);
    end
    @(negedge clk);
    bus.wb_ready = 1'b1;
    #1;
    chk("bp release wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    @(negedge clk);
    #1;
    chk("bp idle_after", {30'd0, dbg_state}, 32'd0);
    chk("bp wb_valid_after", {31'd0, bus.wb_valid}, 32'd0);

    // Flush in WAIT: fsqrt accepted at cycle 0, flush at cycle 2.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = 4'd5;
    bus.in_reg_addr = 6'd21;
    bus.in_dd_val   = 32'h40000000;
    @(negedge clk);
    #1;
    chk("flush pend_c1", {31'd0, bus.pend_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush in_ready_c2", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_inputs();
    #1;
    chk("flush idle_c3", {30'd0, dbg_state}, 32'd0);
    chk("flush pend_c3", {31'd0, bus.pend_valid}, 32'd0);
    begin
      bit saw_wb;
      saw_wb = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        if (bus.wb_valid) saw_wb = 1'b1;
      end
      chk("flush no_wb", {31'd0, saw_wb}, 32'd0);
    end

    // Flush in IDLE: a valid op must not be accepted.
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = 4'd6;
    bus.in_reg_addr = 6'd8;
    bus.in_dd_val   = 32'h5;
    #1;
    chk("flush_idle in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_inputs();
    #1;
    chk("flush_idle pend", {31'd0, bus.pend_valid}, 32'd0);

    // Reset while holding a result in OUT.
    @(negedge clk);
    bus.wb_ready    = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_ctrl     = 4'd6;
    bus.in_reg_addr = 6'd3;
    bus.in_dd_val   = 32'hCAFEF00D;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rstout wb_valid_before", {31'd0, bus.wb_valid}, 32'd1);
    chk("rstout pend_addr_before", {26'd0, bus.pend_addr}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstout wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rstout wb_data", bus.wb_data, 32'd0);
    chk("rstout pend_valid", {31'd0, bus.pend_valid}, 32'd0);
    run_op('{"fadd_after_rst", 4'd1, 6'd10, 32'h41200000, 1, 1'b1});

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
